// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/control-flow sequencer.
package hazard_pkg;

  localparam int unsigned REG_W = 3;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    POP_WAIT  = 2'd1,
    INT_ENTER = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side hazard inputs and stage-control outputs of the hazard sequencer.
interface hazard_controller_if;
  import hazard_pkg::*;

  logic [REG_W-1:0] i_dec_rs;
  logic [REG_W-1:0] i_dec_rt;
  logic             i_dec_uses_rs;
  logic             i_dec_uses_rt;
  logic             i_ex_mem_read;
  logic             i_ex_write_back;
  logic [REG_W-1:0] i_ex_rd;
  logic             i_ex_pop_pc;
  logic             i_ex_branch_taken;
  logic             i_interrupt;
  logic             o_pc_stall;
  logic             o_fd_stall;
  logic             o_fd_flush;
  logic             o_de_flush;
  logic             o_int_inject;
  logic             o_busy;

  modport master (
    output i_dec_rs, i_dec_rt, i_dec_uses_rs, i_dec_uses_rt,
           i_ex_mem_read, i_ex_write_back, i_ex_rd,
           i_ex_pop_pc, i_ex_branch_taken, i_interrupt,
    input  o_pc_stall, o_fd_stall, o_fd_flush, o_de_flush,
           o_int_inject, o_busy
  );

  modport slave (
    input  i_dec_rs, i_dec_rt, i_dec_uses_rs, i_dec_uses_rt,
           i_ex_mem_read, i_ex_write_back, i_ex_rd,
           i_ex_pop_pc, i_ex_branch_taken, i_interrupt,
    output o_pc_stall, o_fd_stall, o_fd_flush, o_de_flush,
           o_int_inject, o_busy
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: decode source matches an in-flight load destination.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic             i_ex_mem_read,
  input  logic             i_ex_write_back,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_dec_rs,
  input  logic [REG_W-1:0] i_dec_rt,
  input  logic             i_dec_uses_rs,
  input  logic             i_dec_uses_rt,
  output logic             o_hit
);

  always_comb begin
    o_hit = i_ex_mem_read & i_ex_write_back &
            ((i_dec_uses_rs & (i_dec_rs == i_ex_rd)) |
             (i_dec_uses_rt & (i_dec_rt == i_ex_rd)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard sequencer: load-use stall, branch squash, multi-cycle PC pop and interrupt entry.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned POP_CYCLES = 2,
  parameter int unsigned INT_CYCLES = 2
) (
  input logic                i_clk,
  input logic                i_reset,
  hazard_controller_if.slave hz
);

  localparam logic [CNT_W-1:0] POP_LOAD = CNT_W'(POP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LOAD = CNT_W'(INT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             int_pend, int_pend_nxt;
  logic             int_accept;
  logic             lu_hit;
  logic             pc_stall, fd_stall, fd_flush, de_flush, int_inject, busy;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read   (hz.i_ex_mem_read),
    .i_ex_write_back (hz.i_ex_write_back),
    .i_ex_rd         (hz.i_ex_rd),
    .i_dec_rs        (hz.i_dec_rs),
    .i_dec_rt        (hz.i_dec_rt),
    .i_dec_uses_rs   (hz.i_dec_uses_rs),
    .i_dec_uses_rt   (hz.i_dec_uses_rt),
    .o_hit           (lu_hit)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    int_accept = 1'b0;
    pc_stall   = 1'b0;
    fd_stall   = 1'b0;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    int_inject = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (hz.i_ex_pop_pc) begin
          pc_stall  = 1'b1;
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
          state_nxt = POP_WAIT;
          cnt_nxt   = POP_LOAD;
        end else if (hz.i_ex_branch_taken) begin
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (int_pend || hz.i_interrupt) begin
          pc_stall   = 1'b1;
          fd_flush   = 1'b1;
          int_inject = 1'b1;
          int_accept = 1'b1;
          state_nxt  = INT_ENTER;
          cnt_nxt    = INT_LOAD;
        end else if (lu_hit) begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
        end
      end
      POP_WAIT, INT_ENTER: begin
        pc_stall = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // A pulse that is not taken this cycle merges into the single pending request.
    if (int_accept)          int_pend_nxt = 1'b0;
    else if (hz.i_interrupt) int_pend_nxt = 1'b1;
    else                     int_pend_nxt = int_pend;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      int_pend <= int_pend_nxt;
    end
  end

  assign hz.o_pc_stall   = pc_stall;
  assign hz.o_fd_stall   = fd_stall;
  assign hz.o_fd_flush   = fd_flush;
  assign hz.o_de_flush   = de_flush;
  assign hz.o_int_inject = int_inject;
  assign hz.o_busy       = busy;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed literal checks plus a cycle-level reference model under random stimulus.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int unsigned POP_C = 2;
  localparam int unsigned INT_C = 3;

  // Output vector order: {pc_stall, fd_stall, fd_flush, de_flush, int_inject, busy}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110100;
  localparam logic [5:0] BR   = 6'b001100;
  localparam logic [5:0] POP0 = 6'b101100;
  localparam logic [5:0] BUSY = 6'b101101;
  localparam logic [5:0] INJ  = 6'b101010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if hif ();

  hazard_controller #(.POP_CYCLES(POP_C), .INT_CYCLES(INT_C)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (hif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [5:0] outs();
    return {hif.o_pc_stall, hif.o_fd_stall, hif.o_fd_flush,
            hif.o_de_flush, hif.o_int_inject, hif.o_busy};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic clr_in();
    hif.i_dec_rs = '0; hif.i_dec_rt = '0;
    hif.i_dec_uses_rs = 1'b0; hif.i_dec_uses_rt = 1'b0;
    hif.i_ex_mem_read = 1'b0; hif.i_ex_write_back = 1'b0; hif.i_ex_rd = '0;
    hif.i_ex_pop_pc = 1'b0; hif.i_ex_branch_taken = 1'b0; hif.i_interrupt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal check of the current cycle, taken mid-way before the falling edge.
  task automatic see(input string name, input logic [5:0] exp);
    #2;
    chk(name, outs(), exp);
  endtask

  // Reference model: remaining busy cycles and one pending-interrupt bit.
  int m_left = 0;
  bit m_pend = 1'b0;

  always @(negedge clk) begin
    logic [5:0] e;
    bit irq, lu;
    if (rst) begin
      m_left = 0;
      m_pend = 1'b0;
    end else begin
      irq = hif.i_interrupt;
      lu  = hif.i_ex_mem_read && hif.i_ex_write_back &&
            ((hif.i_dec_uses_rs && hif.i_dec_rs == hif.i_ex_rd) ||
             (hif.i_dec_uses_rt && hif.i_dec_rt == hif.i_ex_rd));
      if (m_left > 0) begin
        e = BUSY; m_left--;
        if (irq) m_pend = 1'b1;
      end else if (hif.i_ex_pop_pc) begin
        e = POP0; m_left = POP_C;
        if (irq) m_pend = 1'b1;
      end else if (hif.i_ex_branch_taken) begin
        e = BR;
        if (irq) m_pend = 1'b1;
      end else if (m_pend || irq) begin
        e = INJ; m_left = INT_C; m_pend = 1'b0;
      end else if (lu) begin
        e = LU;
      end else begin
        e = NONE;
      end
      chk("model", outs(), e);
    end
  end

  initial begin
    clr_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    see("reset_idle", NONE);

    // Load-use on rs, then the load has moved on.
    tick();
    hif.i_ex_mem_read = 1'b1; hif.i_ex_write_back = 1'b1; hif.i_ex_rd = 3'd3;
    hif.i_dec_rs = 3'd3; hif.i_dec_uses_rs = 1'b1;
    see("loaduse_rs", LU);
    tick(); clr_in();
    see("loaduse_after", NONE);
    tick();
    hif.i_ex_mem_read = 1'b1; hif.i_ex_write_back = 1'b1; hif.i_ex_rd = 3'd3;
    hif.i_dec_rs = 3'd3; hif.i_dec_uses_rs = 1'b0;
    see("loaduse_unused", NONE);
    tick(); clr_in();
    hif.i_ex_mem_read = 1'b1; hif.i_ex_write_back = 1'b1; hif.i_ex_rd = 3'd0;
    hif.i_dec_rt = 3'd0; hif.i_dec_uses_rt = 1'b1; hif.i_dec_rs = 3'd5; hif.i_dec_uses_rs = 1'b1;
    see("loaduse_r0", LU);

    // Branch squash.
    tick(); clr_in(); hif.i_ex_branch_taken = 1'b1;
    see("branch", BR);
    tick(); clr_in();
    see("branch_after", NONE);

    // PC pop: three stall cycles, two of them busy.
    tick(); hif.i_ex_pop_pc = 1'b1;
    see("pop_c0", POP0);
    tick(); clr_in(); see("pop_c1", BUSY);
    tick(); see("pop_c2", BUSY);
    tick(); see("pop_done", NONE);

    // Interrupt arriving in the first wait cycle is held until the pop finishes.
    tick(); hif.i_ex_pop_pc = 1'b1;
    see("popirq_c0", POP0);
    tick(); clr_in(); hif.i_interrupt = 1'b1;
    see("popirq_c1", BUSY);
    tick(); clr_in(); see("popirq_c2", BUSY);
    tick(); see("popirq_inject", INJ);
    for (int i = 0; i < int'(INT_C); i++) begin
      tick(); see("popirq_enter", BUSY);
    end
    tick(); see("popirq_done", NONE);

    // Pop, branch and load-use together: pop wins.
    tick();
    hif.i_ex_pop_pc = 1'b1; hif.i_ex_branch_taken = 1'b1;
    hif.i_ex_mem_read = 1'b1; hif.i_ex_write_back = 1'b1; hif.i_ex_rd = 3'd2;
    hif.i_dec_rs = 3'd2; hif.i_dec_uses_rs = 1'b1;
    see("prio_c0", POP0);
    tick(); clr_in(); see("prio_c1", BUSY);
    tick(); see("prio_c2", BUSY);
    tick(); see("prio_done", NONE);

    // Reset during interrupt entry drops a pending request.
    tick(); hif.i_interrupt = 1'b1;
    see("rst_inject", INJ);
    tick(); see("rst_enter", BUSY);
    tick(); clr_in(); rst = 1'b1;
    tick(); rst = 1'b0;
    see("rst_after0", NONE);
    for (int i = 0; i < 4; i++) begin
      tick(); see("rst_after", NONE);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      hif.i_ex_rd             = 3'($urandom_range(0, 7));
      hif.i_dec_rs            = ($urandom_range(0, 1) == 0) ? hif.i_ex_rd : 3'($urandom_range(0, 7));
      hif.i_dec_rt            = ($urandom_range(0, 2) == 0) ? hif.i_ex_rd : 3'($urandom_range(0, 7));
      hif.i_dec_uses_rs       = 1'($urandom_range(0, 1));
      hif.i_dec_uses_rt       = 1'($urandom_range(0, 1));
      hif.i_ex_mem_read       = 1'($urandom_range(0, 1));
      hif.i_ex_write_back     = ($urandom_range(0, 3) != 0);
      hif.i_ex_pop_pc         = ($urandom_range(0, 15) == 0);
      hif.i_ex_branch_taken   = ($urandom_range(0, 7) == 0);
      hif.i_interrupt         = ($urandom_range(0, 9) == 0);
    end
    tick(); clr_in(); rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and control-flow sequencer sitting beside the decode→execute/memory pipeline register. It consumes that register's outputs (the EX/M-stage control fields) plus decode-stage source indices. It drives the stall and flush inputs of the fetch, fetch/decode and decode/exm stages. Covered hazards: load-use, taken-branch squash, multi-cycle PC-pop (RET/RTI) and interrupt entry.

## Interface
Parameters:
- POP_CYCLES, 2, wait cycles after a PC pop is seen in EX/M (legal 1..7)
- INT_CYCLES, 2, cycles of the interrupt-entry sequence (legal 1..7)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high. Clock is i_clk.
- i_dec_rs  in  3  decode-stage source register 1
- i_dec_rt  in  3  decode-stage source register 2
- i_dec_uses_rs  in  1  decode instruction reads rs
- i_dec_uses_rt  in  1  decode instruction reads rt
- i_ex_mem_read  in  1  EX/M instruction is a load
- i_ex_write_back  in  1  EX/M instruction writes a register
- i_ex_rd  in  3  EX/M destination register
- i_ex_pop_pc  in  1  EX/M instruction pops PC (RET/RTI)
- i_ex_branch_taken  in  1  branch resolved taken in EX/M this cycle
- i_interrupt  in  1  external interrupt request, 1-cycle pulse
- o_pc_stall  out  1  hold PC
- o_fd_stall  out  1  hold fetch/decode register
- o_fd_flush  out  1  clear fetch/decode register
- o_de_flush  out  1  load bubble into decode/exm register
- o_int_inject  out  1  decode issues push-PC/vector micro-op this cycle
- o_busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, POP_WAIT, INT_ENTER. Down-counter cnt is 3 bits. Interrupt-pending flag is int_pend.
- Outputs are combinational from state, cnt and inputs. State, cnt and int_pend are registered.
- IDLE resolves hazards in priority order. The first match applies:
  1. i_ex_pop_pc: assert o_pc_stall, o_fd_flush, o_de_flush. Next state POP_WAIT, cnt←POP_CYCLES-1.
  2. i_ex_branch_taken: assert o_fd_flush and o_de_flush. PC is not stalled, so the branch target loads. Stay IDLE.
  3. int_pend or i_interrupt: assert o_pc_stall, o_fd_flush, o_int_inject. Next state INT_ENTER, cnt←INT_CYCLES-1, clear int_pend.
  4. Load-use: i_ex_mem_read & i_ex_write_back & ((i_dec_uses_rs & i_dec_rs==i_ex_rd) | (i_dec_uses_rt & i_dec_rt==i_ex_rd)). Assert o_pc_stall, o_fd_stall, o_de_flush. Stay IDLE.
  5. Otherwise all outputs are 0.
- POP_WAIT: assert o_pc_stall, o_fd_flush, o_de_flush. If cnt==0, go to IDLE; else cnt−1. Ignore branch and load-use inputs.
- INT_ENTER: assert o_pc_stall, o_fd_flush, o_de_flush; o_int_inject stays 0. If cnt==0, go to IDLE; else cnt−1.
- int_pend:
  - Set by i_interrupt in any state when the interrupt is not accepted that cycle.
  - Cleared only on entry to INT_ENTER.
  - A second pulse while pending is merged into the pending request, not queued.
- Register 0 gets no special treatment; a load-use match on r0 stalls.

## Timing
- Reset: state=IDLE, cnt=0, int_pend=0. All outputs are 0 in the reset cycle and the cycle after, unless inputs trigger IDLE rules.
- Load-use stall lasts exactly 1 cycle. On the next cycle the load has advanced, so the EX/M inputs no longer match.
- Branch squash is 1 cycle with 0 added PC stall.
- PC pop: flush/stall lasts 1+POP_CYCLES cycles, counting the detection cycle.
- Interrupt entry:
  - o_int_inject is high for exactly 1 cycle.
  - PC stall lasts 1+INT_CYCLES cycles.
  - Acceptance latency is 0 cycles from i_interrupt when IDLE with no higher-priority hazard. Otherwise it is accepted on the first IDLE cycle with no pop or branch.
- Pop and branch in the same cycle: pop wins, and the branch is squashed by the flush.
- i_reset mid-POP_WAIT/INT_ENTER returns to IDLE the next cycle, and a pending interrupt is dropped.

## Structure
- Shared package `hazard_pkg`:
  - State enum (IDLE=0, POP_WAIT=1, INT_ENTER=2).
  - Register-index width constant REG_W=3.
- Sub-module `load_use_detect`: combinational comparator producing the rule-4 match. Reusable by the forwarding unit.
- Everything else (FSM, counter, int_pend) lives in the top module.

## Test plan
- Load-use: ex_mem_read=1, ex_write_back=1, ex_rd=3, dec_rs=3, uses_rs=1 → pc_stall, fd_stall and de_flush are high for 1 cycle. Same stimulus with uses_rs=0 → no stall.
- Branch: ex_branch_taken pulse → fd_flush and de_flush for 1 cycle, pc_stall=0, o_busy=0.
- PC pop, POP_CYCLES=2: ex_pop_pc pulse → pc_stall high 3 consecutive cycles, o_busy high 2 cycles, then all outputs 0.
- Interrupt during POP_WAIT: i_interrupt in POP_WAIT cycle 1 → int_inject fires on the first IDLE cycle after the wait, then pc_stall for INT_CYCLES more cycles.
- Priority: pop_pc, branch and a load-use match in the same cycle → POP_WAIT entered, fd_stall=0.
- Reset mid-INT_ENTER: assert i_reset → state IDLE, all outputs 0, int_pend cleared; no int_inject afterwards.
